// File: rtl/uart_packet_tx.sv
// Response-path packet transmitter: frames a 4-byte header (opcode, 0x00,
// length LSB, length MSB) plus payload and serializes every byte 8N1,
// LSB first, on tx_o. Bytes ready to go are sent with no idle gap.
module uart_packet_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_valid_i,
    output logic        start_ready_o,
    input  logic [7:0]  opcode_i,
    input  logic [15:0] length_i,
    input  logic        payload_valid_i,
    input  logic [7:0]  payload_data_i,
    output logic        payload_ready_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {P_IDLE, P_HDR, P_PAY, P_FIN} pkt_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

    pkt_state_t       pkt_st, pkt_nx;
    ser_state_t       ser_st, ser_nx;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [1:0]       hdr_idx;
    logic [15:0]      pay_cnt;
    logic [15:0]      length_q;

    logic       bit_last;
    logic       ser_free;
    logic       load;
    logic [7:0] load_byte;
    logic       start_hs;
    logic       pay_hs;

    // The serializer can take a new byte when idle or in the very last
    // cycle of a stop bit; loading then makes the next start bit gapless.
    assign bit_last = (clk_cnt == CNT_LAST);
    assign ser_free = (ser_st == S_IDLE) || ((ser_st == S_STOP) && bit_last);

    // Packet FSM next state, handshakes and the byte offered to the serializer.
    // The opcode is loaded straight from the start handshake so the start
    // bit appears on the following cycle.
    always_comb begin
        pkt_nx          = pkt_st;
        start_ready_o   = 1'b0;
        payload_ready_o = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        load            = 1'b0;
        load_byte       = 8'h00;
        start_hs        = 1'b0;
        pay_hs          = 1'b0;
        case (pkt_st)
            P_IDLE: begin
                busy_o        = 1'b0;
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    start_hs  = 1'b1;
                    load      = 1'b1;
                    load_byte = opcode_i;
                    pkt_nx    = P_HDR;
                end
            end
            P_HDR: begin
                if (ser_free) begin
                    load = 1'b1;
                    case (hdr_idx)
                        2'd1:    load_byte = 8'h00;
                        2'd2:    load_byte = length_q[7:0];
                        default: load_byte = length_q[15:8];
                    endcase
                    if (hdr_idx == 2'd3)
                        pkt_nx = (pay_cnt != 16'd0) ? P_PAY : P_FIN;
                end
            end
            P_PAY: begin
                payload_ready_o = ser_free;
                if (ser_free && payload_valid_i) begin
                    pay_hs    = 1'b1;
                    load      = 1'b1;
                    load_byte = payload_data_i;
                    if (pay_cnt == 16'd1)
                        pkt_nx = P_FIN;
                end
            end
            default: begin
                // Last stop bit has completed once the serializer is idle.
                if (ser_st == S_IDLE) begin
                    done_o = 1'b1;
                    pkt_nx = P_IDLE;
                end
            end
        endcase
    end

    // Packet state plus header index, latched length and remaining payload count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_st   <= P_IDLE;
            hdr_idx  <= 2'd0;
            pay_cnt  <= 16'd0;
            length_q <= 16'd0;
        end else begin
            pkt_st <= pkt_nx;
            if (start_hs) begin
                length_q <= length_i;
                pay_cnt  <= (length_i > 16'd4) ? (length_i - 16'd4) : 16'd0;
                hdr_idx  <= 2'd1;
            end else if ((pkt_st == P_HDR) && load) begin
                hdr_idx <= hdr_idx + 2'd1;
            end
            if (pay_hs)
                pay_cnt <= pay_cnt - 16'd1;
        end
    end

    // Serializer next state and line level.
    always_comb begin
        ser_nx = ser_st;
        tx_o   = 1'b1;
        case (ser_st)
            S_IDLE:  if (load) ser_nx = S_START;
            S_START: begin
                tx_o = 1'b0;
                if (bit_last) ser_nx = S_DATA;
            end
            S_DATA: begin
                tx_o = shreg[0];
                if (bit_last && (bit_idx == 3'd7)) ser_nx = S_STOP;
            end
            default: if (bit_last) ser_nx = load ? S_START : S_IDLE;
        endcase
    end

    // Serializer state, bit-period counter and shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ser_st  <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            ser_st <= ser_nx;
            if ((ser_st == S_IDLE) || bit_last)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + CNT_W'(1);
            if (load) begin
                shreg   <= load_byte;
                bit_idx <= 3'd0;
            end else if ((ser_st == S_DATA) && bit_last) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx with CLKS_PER_BIT=4 (40 cycles/byte).
module tb_uart_packet_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic [15:0] length = 16'h0000;
    logic        payload_valid = 1'b0;
    logic [7:0]  payload_data = 8'h00;
    logic        start_ready, payload_ready, tx, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] pay_buf [4];
    int         n_pay = 0;

    // UART receiver model and event counters (sampled on the falling edge)
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_start = 0;
    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         frame_err = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         pr_cnt = 0;
    logic       sr_at_done = 1'b0;

    uart_packet_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_valid_i   (start_valid),
        .start_ready_o   (start_ready),
        .opcode_i        (opcode),
        .length_i        (length),
        .payload_valid_i (payload_valid),
        .payload_data_i  (payload_data),
        .payload_ready_o (payload_ready),
        .tx_o            (tx),
        .busy_o          (busy),
        .done_o          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decode 8N1 frames: data bit k sampled at offset 4(k+1)+2, stop at 38.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act   <= 1'b1;
                rx_cnt   <= 0;
                rx_start <= cyc;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if ((rx_cnt + 1) >= 6 && (rx_cnt + 1) <= 34 && ((rx_cnt + 1) % 4) == 2)
                rx_sh <= {tx, rx_sh[7:1]};
            if (rx_cnt == 37 && tx !== 1'b1)
                frame_err <= frame_err + 1;
            if (rx_cnt == 38) begin
                rx_act <= 1'b0;
                rx_q.push_back(rx_sh);
                rx_t.push_back(rx_start);
            end
        end
        if (done === 1'b1) begin
            done_cnt   <= done_cnt + 1;
            done_cyc   <= cyc;
            sr_at_done <= start_ready;
        end
        if (payload_ready === 1'b1) pr_cnt <= pr_cnt + 1;
    end

    // Start a packet, feed payload (optionally stalled), optionally poke a
    // second start request, and wait for done with a cycle bound.
    task automatic run_pkt(input logic [7:0] op, input logic [15:0] len,
                           input int stall, input int poke_at,
                           output int hs_cyc, output int pay_hs_cyc,
                           output logic poke_sr);
        int idx, n0, cnt, stalled;
        logic hs;
        idx = 0; cnt = 0; stalled = 0; n0 = done_cnt;
        pay_hs_cyc = -1; poke_sr = 1'b1;
        @(posedge clk); #1;
        start_valid   = 1'b1;
        opcode        = op;
        length        = len;
        payload_valid = (stall == 0) && (idx < n_pay);
        payload_data  = pay_buf[0];
        @(posedge clk); #1;
        hs_cyc      = cyc;
        start_valid = 1'b0;
        opcode      = 8'hA5;
        length      = 16'h0BAD;
        while (done_cnt == n0 && cnt < 3000) begin
            @(negedge clk);
            hs = payload_valid && payload_ready;
            if (hs) pay_hs_cyc = cyc;
            if (payload_ready && !payload_valid) stalled++;
            if (start_valid) poke_sr = start_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cnt++;
            payload_valid = (stalled >= stall) && (idx < n_pay);
            payload_data  = pay_buf[idx % 4];
            start_valid   = (cnt == poke_at);
            if (start_valid) opcode = 8'h55;
        end
        payload_valid = 1'b0;
        start_valid   = 1'b0;
        checks++;
        if (done_cnt == n0) begin
            errors++;
            $display("FAIL pkt_timeout op=%h done_cnt=%0d expected %0d", op, done_cnt, n0 + 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx, busy, done, payload_ready, start_ready} !== 5'b10001) begin
            errors++;
            $display("FAIL reset_outputs got tx/busy/done/pready/sready=%b expected 10001",
                     {tx, busy, done, payload_ready, start_ready});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_echo();
        logic [7:0] exp [6] = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
        int b, hs, phs, d0;
        logic psr;
        b = rx_q.size(); d0 = done_cnt;
        n_pay = 2; pay_buf[0] = 8'h48; pay_buf[1] = 8'h69;
        run_pkt(8'hEC, 16'h0006, 0, -1, hs, phs, psr);
        checks++;
        if (start_ready !== 1'b1) begin
            errors++; $display("FAIL echo_ready_after_done got %b expected 1", start_ready);
        end
        checks++;
        if (sr_at_done !== 1'b0) begin
            errors++; $display("FAIL echo_ready_during_done got %b expected 0", sr_at_done);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rx_q.size() - b != 6) begin
            errors++; $display("FAIL echo_byte_count got %0d expected 6", rx_q.size() - b);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_q[b + i] !== exp[i]) begin
                errors++; $display("FAIL echo_byte%0d got %h expected %h", i, rx_q[b + i], exp[i]);
            end
        end
        for (int i = 1; i < 6; i++) begin
            checks++;
            if (rx_t[b + i] - rx_t[b + i - 1] != 10 * CPB) begin
                errors++; $display("FAIL echo_gap%0d got %0d expected 40", i, rx_t[b + i] - rx_t[b + i - 1]);
            end
        end
        checks++;
        if (rx_t[b] != hs) begin
            errors++; $display("FAIL echo_first_start got %0d expected %0d", rx_t[b], hs);
        end
        checks++;
        if (done_cyc - rx_t[b] != 240) begin
            errors++; $display("FAIL echo_total_cycles got %0d expected 240", done_cyc - rx_t[b]);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL echo_done_pulses got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (frame_err != 0) begin
            errors++; $display("FAIL echo_stop_bits got %0d bad expected 0", frame_err);
        end
    endtask

    // Header-only and short-length packets; payload_valid held high but never accepted.
    task automatic test_header_only(input logic [7:0] op, input logic [15:0] len);
        logic [7:0] exp [4];
        int b, p0, hs, phs;
        logic psr;
        exp[0] = op; exp[1] = 8'h00; exp[2] = len[7:0]; exp[3] = len[15:8];
        b = rx_q.size(); p0 = pr_cnt;
        n_pay = 1; pay_buf[0] = 8'hFF;
        run_pkt(op, len, 0, -1, hs, phs, psr);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rx_q.size() - b != 4) begin
            errors++; $display("FAIL hdr%0d_byte_count got %0d expected 4", len, rx_q.size() - b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q[b + i] !== exp[i]) begin
                errors++; $display("FAIL hdr%0d_byte%0d got %h expected %h", len, i, rx_q[b + i], exp[i]);
            end
        end
        checks++;
        if (pr_cnt != p0) begin
            errors++; $display("FAIL hdr%0d_payload_ready got %0d cycles expected 0", len, pr_cnt - p0);
        end
        checks++;
        if (done_cyc - rx_t[b] != 160) begin
            errors++; $display("FAIL hdr%0d_done_time got %0d expected 160", len, done_cyc - rx_t[b]);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [5] = '{8'h5A, 8'h00, 8'h05, 8'h00, 8'hC3};
        int b, hs, phs;
        logic psr;
        b = rx_q.size();
        n_pay = 1; pay_buf[0] = 8'hC3;
        run_pkt(8'h5A, 16'h0005, 37, -1, hs, phs, psr);
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[b + i] !== exp[i]) begin
                errors++; $display("FAIL stall_byte%0d got %h expected %h", i, rx_q[b + i], exp[i]);
            end
        end
        checks++;
        if (rx_t[b + 4] - rx_t[b + 3] != 77) begin
            errors++; $display("FAIL stall_gap got %0d expected 77", rx_t[b + 4] - rx_t[b + 3]);
        end
        checks++;
        if (rx_t[b + 4] != phs + 1) begin
            errors++; $display("FAIL stall_start_after_hs got %0d expected %0d", rx_t[b + 4], phs + 1);
        end
    endtask

    task automatic test_busy_reject();
        logic [7:0] exp [6] = '{8'h99, 8'h00, 8'h06, 8'h00, 8'h12, 8'h34};
        int b, hs, phs, d0;
        logic psr;
        b = rx_q.size(); d0 = done_cnt;
        n_pay = 2; pay_buf[0] = 8'h12; pay_buf[1] = 8'h34;
        run_pkt(8'h99, 16'h0006, 0, 50, hs, phs, psr);
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if (psr !== 1'b0) begin
            errors++; $display("FAIL busy_start_ready got %b expected 0", psr);
        end
        checks++;
        if (rx_q.size() - b != 6 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_extra_packet bytes=%0d dones=%0d busy=%b expected 6 1 0",
                               rx_q.size() - b, done_cnt - d0, busy);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_q[b + i] !== exp[i]) begin
                errors++; $display("FAIL busy_byte%0d got %h expected %h", i, rx_q[b + i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [5] = '{8'h3C, 8'h00, 8'h05, 8'h00, 8'hA7};
        int b, hs, phs, d0, p0;
        logic psr;
        d0 = done_cnt;
        @(posedge clk); #1;
        start_valid = 1'b1; opcode = 8'h77; length = 16'h0006;
        @(posedge clk); #1;
        hs = cyc; start_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        // 0x77 has bit 3 clear, so the line is low here
        checks++;
        if (tx !== 1'b0) begin
            errors++; $display("FAIL rstmid_bit3_level got %b expected 0", tx);
        end
        payload_valid = 1'b1;
        p0 = pr_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got tx=%b busy=%b expected 1 0", tx, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || pr_cnt != p0) begin
            errors++; $display("FAIL rstmid_quiet got dones=%0d pready=%0d expected 0 0",
                               done_cnt - d0, pr_cnt - p0);
        end
        payload_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        b = rx_q.size();
        n_pay = 1; pay_buf[0] = 8'hA7;
        run_pkt(8'h3C, 16'h0005, 0, -1, hs, phs, psr);
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[b + i] !== exp[i]) begin
                errors++; $display("FAIL rstmid_after_byte%0d got %h expected %h", i, rx_q[b + i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_header_only(8'h11, 16'h0004);
        test_header_only(8'h22, 16'h0002);
        test_stall();
        test_busy_reject();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_packet_tx.md
Name: uart_packet_tx

Overview:
- Response-path transmitter for the UART ALU: frames a result packet and serializes it 8N1, LSB first, on the UART TX line back to the host.
- Packet format matches the host-to-device format: byte0 opcode, byte1 reserved 0x00, byte2 length LSB, byte3 length MSB, then payload bytes.
- The length field is the total packet size including the 4-byte header.
- Sits between the ALU/echo engine (stream producer) and the FPGA TX pin.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); legal range ≥2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- start_valid_i  in  1  request to send a packet
- start_ready_o  out  1  block idle; accepts a packet request
- opcode_i  in  8  opcode; sampled on start handshake
- length_i  in  16  total packet length; sampled on start handshake
- payload_valid_i  in  1  payload byte available
- payload_data_i  in  8  payload byte
- payload_ready_o  out  1  payload byte accepted this cycle when valid is also high
- tx_o  out  1  UART serial line; idle high
- busy_o  out  1  packet in progress
- done_o  out  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset values (asynchronous, immediate): tx_o=1, busy_o=0, done_o=0, payload_ready_o=0, start_ready_o=1, all counters 0, packet FSM=IDLE, serializer=IDLE.
- Packet FSM:
  - IDLE: start_ready_o=1. On start_valid_i & start_ready_o, latch opcode and length, compute payload count P = (length_i>4) ? length_i-4 : 0, then go to HDR.
  - HDR: send opcode, 0x00, length[7:0], length[15:8], back to back. Then go to PAY if P>0, else go to FIN.
  - PAY: payload_ready_o=1 only when the serializer can load a byte: serializer idle, or final cycle of the stop bit. Each valid&ready decrements P. After the last byte is loaded, go to FIN.
  - FIN: wait for the last stop bit to finish, pulse done_o for 1 cycle, then return to IDLE. start_ready_o=1 the following cycle.
- busy_o=1 in every state other than IDLE.
- Serializer states:
  - IDLE: tx_o=1.
  - START: tx_o=0.
  - DATA: 8 bits, LSB first.
  - STOP: tx_o=1.
  - Each bit lasts exactly CLKS_PER_BIT cycles; one byte takes 10*CLKS_PER_BIT cycles.
- Timing:
  - tx_o falls to the start bit the cycle after the start handshake.
  - Consecutive bytes with data available have zero idle cycles: the next start bit follows directly after the stop bit.
  - Payload stall (payload_valid_i low in PAY): serializer idles with tx_o=1. The start bit begins the cycle after the handshake.
- Length rules:
  - length_i<4 still transmits the header with length_i verbatim, with no payload.
  - length_i=0xFFFF gives P=65531; the counter is 16 bits and does not wrap.
- start_valid_i while busy_o=1 is ignored; the request is not queued.
- payload_valid_i outside PAY is ignored and never acknowledged.
- Input stability: opcode_i/length_i changes after the handshake have no effect. payload_data_i is captured at the handshake.
- Reset mid-packet: line returns high immediately, no done_o, remaining payload is not consumed.

Test Plan:
- Echo packet (CLKS_PER_BIT=4): opcode 0xEC, length 0x0006, payload 0x48,0x69 with valid always high -> tx_o decodes EC 00 06 00 48 69. Gapless, total 240 cycles from the first start bit. done_o pulses once. start_ready_o=1 the cycle after done_o.
- Header-only: opcode 0x11, length 4 -> bytes 11 00 04 00, payload_ready_o never asserted, done_o after 160 cycles.
- Short length: length 2 -> bytes xx 00 02 00, no payload requested, done_o pulses.
- Payload stall: length 5, payload_valid_i held low 37 cycles after the header -> tx_o stays 1 for the gap. Start bit begins the cycle after the handshake; the byte is correct.
- Busy rejection: pulse start_valid_i with opcode 0x55 mid-packet -> start_ready_o=0, the current packet is unaltered, no second packet is sent.
- Reset mid-byte: assert rst_ni=0 during DATA bit 3 -> tx_o=1 and busy_o=0 asynchronously, no done_o. A new packet is sent correctly after release.
